// File: rtl/nf_ram_ctrl.sv
// rtl/nf_ram_ctrl.sv - byte/half/word bus front end for a word-wide RAM without byte enables
module nf_ram_ctrl #(
    parameter int depth = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ack,
    output logic        err,
    output logic [31:0] ram_addr,
    output logic        ram_we,
    output logic [31:0] ram_wd,
    input  logic [31:0] ram_rd
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP,
        ERR
    } state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [15:0] wd_q;
    logic [31:0] buf_q;
    logic [31:0] rd_q;
    logic        bad_req;
    logic [31:0] lane_rd;
    logic [31:0] merged;

    // Out-of-range indices are rejected rather than aliased onto a smaller RAM.
    always_comb begin
        bad_req = 1'b0;
        if (size == 2'b11)
            bad_req = 1'b1;
        else if (size == 2'b01 && addr[0])
            bad_req = 1'b1;
        else if (size == 2'b10 && addr[1:0] != 2'b00)
            bad_req = 1'b1;
        if (addr[31:2] >= 30'(depth))
            bad_req = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (bad_req)
                        state_nx = ERR;
                    else if (!we)
                        state_nx = RD;
                    else if (size == 2'b10)
                        state_nx = WR;
                    else
                        state_nx = RMW_RD;
                end
            end
            RD:      state_nx = RESP;
            RMW_RD:  state_nx = WR;
            WR:      state_nx = RESP;
            RESP:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Lane extraction for loads and lane overwrite for sub-word stores.
    always_comb begin
        lane_rd = '0;
        merged  = ram_rd;
        case (size_q)
            2'b00: begin
                lane_rd[7:0] = ram_rd[{addr_q[1:0], 3'b000} +: 8];
                merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
            end
            2'b01: begin
                lane_rd[15:0] = ram_rd[{addr_q[1], 4'b0000} +: 16];
                merged[{addr_q[1], 4'b0000} +: 16] = wd_q;
            end
            default: lane_rd = ram_rd;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // buf_q doubles as the word-store data so WR always drives from one register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            size_q <= '0;
            wd_q   <= '0;
            buf_q  <= '0;
            rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= addr;
                        size_q <= size;
                        wd_q   <= wd[15:0];
                        buf_q  <= wd;
                        if (bad_req)
                            rd_q <= '0;
                    end
                end
                RD:      rd_q  <= lane_rd;
                RMW_RD:  buf_q <= merged;
                default: ;
            endcase
        end
    end

    assign ack      = (state == RESP) || (state == ERR);
    assign err      = (state == ERR);
    assign ram_we   = (state == WR);
    assign ram_wd   = ram_we ? buf_q : '0;
    assign ram_addr = {2'b00, addr_q[31:2]};
    assign rd       = rd_q;

endmodule

// File: tb/tb_nf_ram_ctrl.sv
// tb/tb_nf_ram_ctrl.sv - table-driven and randomized checks of nf_ram_ctrl against a memory model
module tb_nf_ram_ctrl;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  size = '0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        ack;
    logic        err;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    nf_ram_ctrl #(.depth(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .req(req), .we(we), .addr(addr), .size(size),
        .wd(wd), .rd(rd), .ack(ack), .err(err), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wd(ram_wd), .ram_rd(ram_rd)
    );

    always #5 clk = ~clk;

    assign ram_rd = (ram_addr < DEPTH) ? mem[ram_addr[5:0]] : 32'h0;

    always @(posedge clk)
        if (ram_we && ram_addr < DEPTH)
            mem[ram_addr[5:0]] <= ram_wd;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_nwr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic on a plain array; updates ref_mem on successful stores.
    task automatic model(input logic m_we, input logic [31:0] m_addr, input logic [1:0] m_size,
                         input logic [31:0] m_wd, output logic [31:0] e_rd, output logic e_err,
                         output int e_lat, output int e_nwr, output logic [31:0] e_wd);
        int unsigned idx, sh;
        logic [31:0] mask, old;
        idx = m_addr / 4;
        sh = 8 * (m_addr % 4);
        mask = (m_size == 2'd0) ? 32'hFF : (m_size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        e_rd = 0; e_err = 0; e_nwr = 0; e_wd = 0; e_lat = 2;
        if (m_size == 2'd3 || (m_size == 2'd1 && m_addr % 2 != 0) ||
            (m_size == 2'd2 && m_addr % 4 != 0) || idx >= DEPTH) begin
            e_err = 1; e_lat = 1;
        end else if (!m_we) begin
            e_rd = (ref_mem[idx] >> sh) & mask;
        end else begin
            old = ref_mem[idx];
            e_wd = (old & ~(mask << sh)) | ((m_wd & mask) << sh);
            e_nwr = 1;
            e_lat = (m_size == 2'd2) ? 2 : 3;
            ref_mem[idx] = e_wd;
        end
    endtask

    task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [1:0] t_size,
                           input logic [31:0] t_wd, input bit scramble,
                           output logic [31:0] o_rd, output logic o_err, output int o_lat,
                           output int o_nwr, output logic [31:0] o_wd, output logic [31:0] o_waddr);
        @(negedge clk);
        req = 1'b1; we = t_we; addr = t_addr; size = t_size; wd = t_wd;
        o_rd = 0; o_err = 0; o_lat = 0; o_nwr = 0; o_wd = 0; o_waddr = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (scramble && n == 1) begin
                addr = $urandom; wd = $urandom; size = 2'($urandom_range(0, 3)); we = ~we;
            end
            if (ram_we) begin
                o_nwr++; o_wd = ram_wd; o_waddr = ram_addr;
            end
            if (ack) begin
                o_lat = n; o_rd = rd; o_err = err;
                break;
            end
        end
        req = 1'b0;
    endtask

    task automatic apply_and_check(input string tag, input logic t_we, input logic [31:0] t_addr,
                                   input logic [1:0] t_size, input logic [31:0] t_wd, input bit scramble,
                                   input logic [31:0] e_rd, input logic e_err, input int e_lat,
                                   input int e_nwr, input logic [31:0] e_wd);
        logic [31:0] g_rd, g_wd, g_waddr;
        logic g_err;
        int g_lat, g_nwr;
        run_txn(t_we, t_addr, t_size, t_wd, scramble, g_rd, g_err, g_lat, g_nwr, g_wd, g_waddr);
        check({tag, " latency"}, 32'(g_lat), 32'(e_lat));
        check({tag, " err"}, {31'b0, g_err}, {31'b0, e_err});
        check({tag, " ram_we count"}, 32'(g_nwr), 32'(e_nwr));
        if (!t_we || e_err)
            check({tag, " rd"}, g_rd, e_rd);
        if (e_nwr != 0) begin
            check({tag, " ram_wd"}, g_wd, e_wd);
            check({tag, " ram_addr"}, g_waddr, t_addr >> 2);
        end
    endtask

    initial begin
        logic [31:0] e_rd, e_wd;
        logic e_err;
        int e_lat, e_nwr, first_ack, second_ack;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 0; ref_mem[i] = 0;
        end

        tbl[0]  = '{1'b1, 32'h10,  2'd2, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 32'h10,  2'd2, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0};
        tbl[2]  = '{1'b1, 32'h10,  2'd2, 32'h11223344, 32'h0,        1'b0, 2, 1, 32'h11223344};
        tbl[3]  = '{1'b1, 32'h12,  2'd0, 32'hFFFFFFAA, 32'h0,        1'b0, 3, 1, 32'h11AA3344};
        tbl[4]  = '{1'b0, 32'h12,  2'd0, 32'h0,        32'h000000AA, 1'b0, 2, 0, 32'h0};
        tbl[5]  = '{1'b0, 32'h10,  2'd1, 32'h0,        32'h00003344, 1'b0, 2, 0, 32'h0};
        tbl[6]  = '{1'b0, 32'h12,  2'd1, 32'h0,        32'h000011AA, 1'b0, 2, 0, 32'h0};
        tbl[7]  = '{1'b0, 32'h13,  2'd0, 32'h0,        32'h00000011, 1'b0, 2, 0, 32'h0};
        tbl[8]  = '{1'b1, 32'h13,  2'd1, 32'h0000BEEF, 32'h0,        1'b1, 1, 0, 32'h0};
        tbl[9]  = '{1'b0, 32'h11,  2'd2, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        tbl[10] = '{1'b0, 32'h0,   2'd3, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
        tbl[11] = '{1'b1, 32'h100, 2'd2, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0};
        tbl[12] = '{1'b0, 32'hFC,  2'd2, 32'h0,        32'h0,        1'b0, 2, 0, 32'h0};
        tbl[13] = '{1'b0, 32'h10,  2'd2, 32'h0,        32'h11AA3344, 1'b0, 2, 0, 32'h0};

        repeat (3) @(negedge clk);
        check("reset rd", rd, 32'h0);
        check("reset ack/err/ram_we", {29'b0, ack, err, ram_we}, 32'h0);
        check("reset ram_wd", ram_wd, 32'h0);
        check("reset ram_addr", ram_addr, 32'h0);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            model(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wd, e_rd, e_err, e_lat, e_nwr, e_wd);
            apply_and_check($sformatf("tbl[%0d]", i), tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wd, 1'b0,
                            tbl[i].exp_rd, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_nwr, tbl[i].exp_wd);
        end
        check("out-of-range store left word 0", mem[0], ref_mem[0]);

        // Reset during WR of a byte store: the write must never land.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h21; size = 2'd0; wd = 32'h5A;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("abort ram_we in WR", {31'b0, ram_we}, 32'h1);
        resetn = 1'b0;
        #1;
        check("abort ram_we after reset", {31'b0, ram_we}, 32'h0);
        check("abort ack after reset", {31'b0, ack}, 32'h0);
        check("abort ram_addr after reset", ram_addr, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        check("abort word 8 unchanged", mem[8], ref_mem[8]);
        model(1'b1, 32'h21, 2'd0, 32'h5A, e_rd, e_err, e_lat, e_nwr, e_wd);
        apply_and_check("reissue", 1'b1, 32'h21, 2'd0, 32'h5A, 1'b0, e_rd, e_err, e_lat, e_nwr, e_wd);

        // req held high across ack: back-to-back loads.
        model(1'b0, 32'h0, 2'd2, 32'h0, e_rd, e_err, e_lat, e_nwr, e_wd);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0; size = 2'd2; wd = 32'h0;
        first_ack = -1; second_ack = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ack) begin
                if (first_ack < 0) begin
                    first_ack = n;
                    check("b2b first rd", rd, e_rd);
                end else begin
                    second_ack = n;
                    check("b2b second rd", rd, e_rd);
                    break;
                end
            end
        end
        req = 1'b0;
        check("b2b first ack latency", 32'(first_ack), 32'd2);
        check("b2b ack spacing", 32'(second_ack - first_ack), 32'd3);

        for (int i = 0; i < 400; i++) begin
            logic r_we;
            logic [31:0] r_addr, r_wd;
            logic [1:0] r_size;
            r_we = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 4 * DEPTH + 15);
            r_size = 2'($urandom_range(0, 3));
            r_wd = $urandom;
            model(r_we, r_addr, r_size, r_wd, e_rd, e_err, e_lat, e_nwr, e_wd);
            apply_and_check($sformatf("rnd[%0d]", i), r_we, r_addr, r_size, r_wd, ($urandom_range(0, 3) == 0),
                            e_rd, e_err, e_lat, e_nwr, e_wd);
        end

        for (int i = 0; i < DEPTH; i++)
            check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
